// File: rtl/mc_ctrl_pkg.sv
// +------------------------------------------------------------------+
// | mc_ctrl_pkg : shared encodings for the multicycle MIPS controller |
// | Rev 1.0                                                           |
// +------------------------------------------------------------------+
`default_nettype none

package mc_ctrl_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_JR    = 6'h08;
  localparam logic [5:0] FN_ADDU  = 6'h21;
  localparam logic [5:0] FN_SUBU  = 6'h23;

  localparam logic [1:0] EXT_ZERO   = 2'd0;
  localparam logic [1:0] EXT_SIGNED = 2'd1;
  localparam logic [1:0] EXT_LUI    = 2'd2;

  localparam logic [2:0] ALU_ADD = 3'd0;
  localparam logic [2:0] ALU_SUB = 3'd1;
  localparam logic [2:0] ALU_OR  = 3'd2;
  localparam logic [2:0] ALU_LUI = 3'd3;

  localparam logic [1:0] NPC_PC4 = 2'd0;
  localparam logic [1:0] NPC_BR  = 2'd1;
  localparam logic [1:0] NPC_J   = 2'd2;
  localparam logic [1:0] NPC_JR  = 2'd3;

  localparam logic [1:0] DST_RT  = 2'd0;
  localparam logic [1:0] DST_RD  = 2'd1;
  localparam logic [1:0] DST_R31 = 2'd2;

  localparam logic [1:0] WD_ALU = 2'd0;
  localparam logic [1:0] WD_MEM = 2'd1;
  localparam logic [1:0] WD_PC4 = 2'd2;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5
  } state_t;

  // Instruction class, exactly one bit set for any opcode/funct pair
  typedef struct packed {
    logic addu;
    logic subu;
    logic jr;
    logic nop;
    logic ori;
    logic lui;
    logic lw;
    logic sw;
    logic beq;
    logic j;
    logic jal;
    logic ill;
  } cls_t;

endpackage

`default_nettype wire

// File: rtl/mc_ctrl_if.sv
// +------------------------------------------------------------------+
// | mc_ctrl_if : controller <-> datapath signal bundle                |
// | Rev 1.0                                                           |
// +------------------------------------------------------------------+
`default_nettype none

interface mc_ctrl_if;
  logic [5:0] opcode;
  logic [5:0] funct;
  logic       zero;
  logic       mem_ready;
  logic       pc_we;
  logic       ir_we;
  logic       reg_we;
  logic       mem_we;
  logic       instr_done;
  logic       illegal;
  logic [1:0] ext_op;
  logic [2:0] alu_op;
  logic       alu_src_b;
  logic [1:0] reg_dst;
  logic [1:0] wd_sel;
  logic [1:0] npc_sel;
  logic [2:0] state;

  modport master (
    input  opcode, funct, zero, mem_ready,
    output pc_we, ir_we, reg_we, mem_we, instr_done, illegal,
           ext_op, alu_op, alu_src_b, reg_dst, wd_sel, npc_sel, state
  );

  modport slave (
    output opcode, funct, zero, mem_ready,
    input  pc_we, ir_we, reg_we, mem_we, instr_done, illegal,
           ext_op, alu_op, alu_src_b, reg_dst, wd_sel, npc_sel, state
  );
endinterface

`default_nettype wire

// File: rtl/mc_decode.sv
// +------------------------------------------------------------------+
// | mc_decode : opcode/funct -> one-hot instruction class             |
// | Rev 1.0                                                           |
// +------------------------------------------------------------------+
`default_nettype none

module mc_decode
  import mc_ctrl_pkg::*;
(
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  output cls_t       cls
);

  always_comb begin
    cls = '0;
    case (opcode)
      OP_RTYPE: begin
        case (funct)
          FN_ADDU: cls.addu = 1'b1;
          FN_SUBU: cls.subu = 1'b1;
          FN_JR:   cls.jr   = 1'b1;
          default: cls.nop  = 1'b1;
        endcase
      end
      OP_J:    cls.j   = 1'b1;
      OP_JAL:  cls.jal = 1'b1;
      OP_BEQ:  cls.beq = 1'b1;
      OP_ORI:  cls.ori = 1'b1;
      OP_LUI:  cls.lui = 1'b1;
      OP_LW:   cls.lw  = 1'b1;
      OP_SW:   cls.sw  = 1'b1;
      default: cls.ill = 1'b1;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/mc_ctrl.sv
// +------------------------------------------------------------------+
// | mc_ctrl : multicycle MIPS control FSM; MC_MEM_WAIT_EN adds a      |
// |           mem_ready stall in MEM.                     Rev 1.0    |
// +------------------------------------------------------------------+
`default_nettype none

module mc_ctrl
  import mc_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        reset_n,
  mc_ctrl_if.master   bus
);

  state_t state_q;
  state_t state_d;
  cls_t   cls;

  mc_decode u_decode (
    .opcode (bus.opcode),
    .funct  (bus.funct),
    .cls    (cls)
  );

`ifndef MC_MEM_WAIT_EN
  logic unused_mem_ready;
  assign unused_mem_ready = bus.mem_ready;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  assign bus.state = state_q;

  // Operand controls depend only on the held opcode, so they stay stable for the whole instruction
  always_comb begin
    bus.ext_op    = EXT_SIGNED;
    bus.alu_src_b = 1'b0;
    bus.alu_op    = ALU_ADD;
    if (state_q inside {S_DECODE, S_EXEC, S_MEM, S_WB}) begin
      if (cls.ori)      bus.ext_op = EXT_ZERO;
      else if (cls.lui) bus.ext_op = EXT_LUI;
      bus.alu_src_b = cls.ori | cls.lui | cls.lw | cls.sw;
      if (cls.subu | cls.beq) bus.alu_op = ALU_SUB;
      else if (cls.ori)       bus.alu_op = ALU_OR;
      else if (cls.lui)       bus.alu_op = ALU_LUI;
    end
  end

  always_comb begin
    state_d        = S_IDLE;
    bus.pc_we      = 1'b0;
    bus.ir_we      = 1'b0;
    bus.reg_we     = 1'b0;
    bus.mem_we     = 1'b0;
    bus.instr_done = 1'b0;
    bus.illegal    = 1'b0;
    bus.npc_sel    = NPC_PC4;
    bus.reg_dst    = DST_RT;
    bus.wd_sel     = WD_ALU;
    case (state_q)
      S_IDLE: state_d = S_FETCH;
      S_FETCH: begin
        bus.ir_we = 1'b1;
        bus.pc_we = 1'b1;
        state_d   = S_DECODE;
      end
      S_DECODE: begin
        state_d = S_EXEC;
        if (cls.j | cls.jal) begin
          bus.pc_we      = 1'b1;
          bus.npc_sel    = NPC_J;
          bus.instr_done = 1'b1;
          state_d        = S_FETCH;
          if (cls.jal) begin
            bus.reg_we  = 1'b1;
            bus.reg_dst = DST_R31;
            bus.wd_sel  = WD_PC4;
          end
        end else if (cls.jr) begin
          bus.pc_we      = 1'b1;
          bus.npc_sel    = NPC_JR;
          bus.instr_done = 1'b1;
          state_d        = S_FETCH;
        end else if (cls.ill | cls.nop) begin
          bus.illegal    = cls.ill;
          bus.instr_done = 1'b1;
          state_d        = S_FETCH;
        end
      end
      S_EXEC: begin
        if (cls.beq) begin
          bus.pc_we      = bus.zero;
          bus.npc_sel    = NPC_BR;
          bus.instr_done = 1'b1;
          state_d        = S_FETCH;
        end else if (cls.lw | cls.sw) begin
          state_d = S_MEM;
        end else if (cls.addu | cls.subu | cls.ori | cls.lui) begin
          state_d = S_WB;
        end else begin
          state_d = S_FETCH;
        end
      end
      S_MEM: begin
`ifdef MC_MEM_WAIT_EN
        bus.mem_we = cls.sw;
        if (!bus.mem_ready) begin
          state_d = S_MEM;
        end else if (cls.sw) begin
          bus.instr_done = 1'b1;
          state_d        = S_FETCH;
        end else begin
          state_d = S_WB;
        end
`else
        if (cls.sw) begin
          bus.mem_we     = 1'b1;
          bus.instr_done = 1'b1;
          state_d        = S_FETCH;
        end else begin
          state_d = S_WB;
        end
`endif
      end
      S_WB: begin
        bus.reg_we     = 1'b1;
        bus.reg_dst    = (cls.addu | cls.subu) ? DST_RD : DST_RT;
        bus.wd_sel     = cls.lw ? WD_MEM : WD_ALU;
        bus.instr_done = 1'b1;
        state_d        = S_FETCH;
      end
      default: state_d = S_IDLE;
    endcase
  end

endmodule

`default_nettype wire

// File: doc/mc_ctrl.md
MC_CTRL -- requirements
Module: mc_ctrl

Interface
REQ-001 SHALL have ports: clk  in  1  rising-edge clock; reset_n  in  1  asynchronous active-low reset.
REQ-002 SHALL have ports: opcode  in  6  IR[31:26]; funct  in  6  IR[5:0]; zero  in  1  ALU equality flag; mem_ready  in  1  data-memory ready (used only under MC_MEM_WAIT_EN).
REQ-003 SHALL have ports: pc_we, ir_we, reg_we, mem_we  out  1  each a write enable; instr_done  out  1  retire pulse; illegal  out  1  unknown-opcode pulse.
REQ-004 SHALL have ports: ext_op  out  2  immediate-extender mode; alu_op  out  3; alu_src_b  out  1  (0 reg, 1 extended imm); reg_dst  out  2  (rt/rd/$31); wd_sel  out  2  (ALU/mem/PC+4); npc_sel  out  2  (PC+4/branch/j/jr); state  out  3  debug.

Function
REQ-005 SHALL implement a registered FSM with states IDLE, FETCH, DECODE, EXEC, MEM, WB; all other outputs SHALL be combinational functions of state, opcode, funct and zero.
REQ-006 SHALL support addu, subu, jr, ori, lui, lw, sw, beq, j, jal; opcode 0 with any other funct SHALL be treated as nop.
REQ-007 IDLE SHALL go to FETCH unconditionally, with all enables 0.
REQ-008 FETCH SHALL assert ir_we=1, pc_we=1, npc_sel=PC+4, then go to DECODE.
REQ-009 DECODE SHALL drive ext_op: ori -> ZERO; lw/sw/beq -> SIGNED; lui -> EXT_LUI; other -> SIGNED.
REQ-010 DECODE, j: pc_we=1, npc_sel=j, instr_done=1, -> FETCH; jal: additionally reg_we=1, reg_dst=$31, wd_sel=PC+4; jr: pc_we=1, npc_sel=jr, instr_done=1, -> FETCH.
REQ-011 DECODE with an unsupported opcode SHALL pulse illegal=1 and instr_done=1 for one cycle and go to FETCH with no write enable asserted.
REQ-012 EXEC, beq: pc_we=zero, npc_sel=branch, instr_done=1, -> FETCH; lw/sw -> MEM; R-type, ori, lui -> WB.
REQ-013 ext_op and alu_src_b SHALL remain stable from DECODE through the last state of the instruction.
REQ-014 MEM, sw: mem_we=1, instr_done=1, -> FETCH; lw -> WB.
REQ-015 WB SHALL assert reg_we=1 (reg_dst=rd for R-type, rt otherwise; wd_sel=mem for lw, ALU otherwise) and instr_done=1, then go to FETCH.
REQ-016 Cycle counts from FETCH entry SHALL be: j/jal/jr 2, beq 3, R/ori/lui/sw 4, lw 5.
REQ-017 An unreachable state encoding SHALL go to IDLE on the next edge with all enables 0.

Reset
REQ-018 reset_n=0 SHALL force state=IDLE immediately and hold every enable, instr_done and illegal at 0 while asserted.
REQ-019 Reset asserted mid-instruction SHALL abort it with no further write; execution SHALL resume via IDLE -> FETCH.

Configuration
REQ-020 With MC_MEM_WAIT_EN defined, MEM SHALL hold its outputs (mem_we held for sw) and remain in MEM until mem_ready=1; exit and instr_done SHALL occur in the cycle with mem_ready=1.
REQ-021 Without MC_MEM_WAIT_EN, mem_ready SHALL be ignored and MEM SHALL last exactly one cycle.

Structure
REQ-022 Opcode/funct values, ext_op codes (ZERO, SIGNED, EXT_LUI), alu_op codes, mux-select codes and state encodings SHALL reside in the shared macro package.
REQ-023 A combinational sub-module mc_decode (opcode, funct -> instruction-class one-hot) SHALL be used; the FSM and output logic SHALL remain in mc_ctrl.

Verification
REQ-024 Release reset, opcode=ori (0x0D) -> states IDLE, FETCH, DECODE, EXEC, WB; ext_op=ZERO; reg_we=1 only in WB; instr_done on cycle 4 after FETCH.
REQ-025 lui (0x0F) -> ext_op=EXT_LUI in DECODE/EXEC/WB; lw (0x23) -> 5 cycles, wd_sel=mem in WB.
REQ-026 beq (0x04) with zero=1 -> pc_we=1 in EXEC; with zero=0 -> pc_we=0, instr_done=1.
REQ-027 jal (0x03) -> reg_we=1, reg_dst=$31, npc_sel=j in DECODE, next state FETCH; opcode 0x3F -> illegal pulse, no enables.
REQ-028 MC_MEM_WAIT_EN, sw with mem_ready low 3 cycles -> mem_we high 4 cycles, single instr_done; reset_n low during MEM -> mem_we falls at once, state=IDLE.
